cfg_mem_loader: RTL

//  Sequencer that bulk-loads a block of configuration words from the config memory into a downstream register write port.

---
 rtl/cfg_mem_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cfg_mem_loader.sv
// Bulk loader: streams word_num words from config memory starting at base_addr
// into an indexed register write port, buffering returns in a small FIFO.
module cfg_mem_loader #(
    parameter int U_DLY      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [15:0] word_num,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
    output logic        mem_rd_en,
    output logic [15:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_data_valid,
    output logic        cfg_wr_en,
    output logic [15:0] cfg_wr_addr,
    output logic [31:0] cfg_wr_data,
    input  logic        cfg_wr_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   base_q, base_d;
    logic [15:0]   num_q, num_d;
    logic [15:0]   rd_cnt_q, rd_cnt_d;
    logic [15:0]   wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   sum_q, sum_d;
    logic [31:0]   fifo_mem_q [FIFO_DEPTH];
    logic [31:0]   fifo_mem_d [FIFO_DEPTH];

    logic loading;
    logic fifo_empty;
    logic credit_ok;
    logic rd_issue;
    logic push;
    logic pop;

    // Delay parameter is kept for interface compatibility only.
    logic unused_u_dly;
    assign unused_u_dly = (U_DLY != 0);

    assign loading    = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign fifo_empty = (fifo_cnt_q == '0);
    // Reads in flight already own a FIFO slot, so they count against the credit.
    assign credit_ok  = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < (CW + 1)'(FIFO_DEPTH);
    assign rd_issue   = (state_q == ST_READ) && (rd_cnt_q != num_q) && credit_ok;
    assign push       = mem_rd_data_valid && loading;
    assign pop        = !fifo_empty && cfg_wr_ready;

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);
    assign sum         = sum_q;
    assign mem_rd_en   = rd_issue;
    assign mem_rd_addr = rd_issue ? (base_q + rd_cnt_q) : 16'h0000;
    assign cfg_wr_en   = !fifo_empty;
    assign cfg_wr_addr = fifo_empty ? 16'h0000 : wr_cnt_q;
    assign cfg_wr_data = fifo_empty ? 32'h0000_0000 : fifo_mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sum_d      = sum_q;

        if (rd_issue) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (rd_issue && !push) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!rd_issue && push && (inflight_q != '0)) begin
            inflight_d = inflight_q - 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            wr_cnt_d = wr_cnt_q + 16'd1;
            sum_d    = sum_q + cfg_wr_data;
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    num_d    = word_num;
                    sum_d    = 32'h0000_0000;
                    rd_cnt_d = 16'd0;
                    wr_cnt_d = 16'd0;
                    state_d  = (word_num != 16'd0) ? ST_READ : ST_FINISH;
                end
            end
            ST_READ: begin
                if (rd_issue && (rd_cnt_d == num_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_cnt_d == num_q) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_d[i] = fifo_mem_q[i];
            if (push && (wr_ptr_q == PW'(i))) begin
                fifo_mem_d[i] = mem_rd_data;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sum_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sum_q      <= sum_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= fifo_mem_d[i];
            end
        end
    end

endmodule
